// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions used by the fetch stage and its IF/ID register.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01,
        DRAIN = 2'b10
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: holds on stall, flush inserts a NOP bubble.
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    input  logic        load_valid,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic        valid_D
);

    // Flush beats enable so a bubble is inserted even while decode is stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_D <= NOP_INSTR;
            pc_D    <= 32'h0000_0000;
            valid_D <= 1'b0;
        end else if (flush) begin
            instr_D <= NOP_INSTR;
            valid_D <= 1'b0;
        end else if (en) begin
            instr_D <= load_instr;
            pc_D    <= load_pc;
            valid_D <= load_valid;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, imem request FSM, one-entry skid and IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_F,
    input  logic        stall_D,
    input  logic        flush_D,
    input  logic        jumping,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic        valid_D,
    output logic        fetch_busy
);

    fetch_state_e state_r, state_nxt_s;
    logic [31:0]  pc_r, pc_nxt_s;
    logic         req_r;
    logic [31:0]  tgt_r, tgt_nxt_s;
    logic [31:0]  skid_instr_r, skid_instr_nxt_s;
    logic [31:0]  skid_pc_r, skid_pc_nxt_s;
    logic         skid_valid_r, skid_valid_nxt_s;
    logic [31:0]  load_instr_s, load_pc_s;
    logic         load_valid_s;
    logic         xfer_s;
    logic [31:0]  jt_s, pc_inc_s, drain_tgt_s;

    assign imem_req   = req_r;
    assign imem_addr  = word_align(pc_r);
    assign fetch_busy = req_r & ~imem_ready;
    assign xfer_s     = req_r & imem_ready;
    assign jt_s       = word_align(jump_target);
    assign pc_inc_s   = pc_r + 32'd4;

    // Next-state, PC, skid and IF/ID load selection.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        tgt_nxt_s        = tgt_r;
        skid_instr_nxt_s = skid_instr_r;
        skid_pc_nxt_s    = skid_pc_r;
        skid_valid_nxt_s = skid_valid_r;
        load_instr_s     = NOP_INSTR;
        load_pc_s        = pc_r;
        load_valid_s     = 1'b0;
        drain_tgt_s      = jumping ? jt_s : tgt_r;

        case (state_r)
            FETCH: begin
                if (jumping) begin
                    skid_valid_nxt_s = 1'b0;
                    // A request already on the bus must complete before redirecting.
                    if (fetch_busy) begin
                        tgt_nxt_s   = jt_s;
                        state_nxt_s = DRAIN;
                    end else begin
                        pc_nxt_s    = jt_s;
                        state_nxt_s = FETCH;
                    end
                end else if (xfer_s) begin
                    if (stall_D) begin
                        skid_instr_nxt_s = imem_rdata;
                        skid_pc_nxt_s    = pc_r;
                        skid_valid_nxt_s = 1'b1;
                        pc_nxt_s         = pc_inc_s;
                        state_nxt_s      = HOLD;
                    end else begin
                        load_instr_s = imem_rdata;
                        load_pc_s    = pc_r;
                        load_valid_s = 1'b1;
                        if (!stall_F) begin
                            pc_nxt_s = pc_inc_s;
                        end else begin
                            pc_nxt_s = pc_r;
                        end
                    end
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            HOLD: begin
                if (jumping) begin
                    pc_nxt_s         = jt_s;
                    skid_valid_nxt_s = 1'b0;
                    state_nxt_s      = FETCH;
                end else if (!stall_D && !flush_D) begin
                    load_instr_s     = skid_instr_r;
                    load_pc_s        = skid_pc_r;
                    load_valid_s     = skid_valid_r;
                    skid_valid_nxt_s = 1'b0;
                    state_nxt_s      = FETCH;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            DRAIN: begin
                if (xfer_s) begin
                    pc_nxt_s    = drain_tgt_s;
                    state_nxt_s = FETCH;
                end else begin
                    tgt_nxt_s   = drain_tgt_s;
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                skid_valid_nxt_s = 1'b0;
                state_nxt_s      = FETCH;
            end
        endcase
    end

    // Fetch state, PC, pending redirect target and skid entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= FETCH;
            pc_r         <= RESET_PC;
            req_r        <= 1'b0;
            tgt_r        <= 32'h0000_0000;
            skid_instr_r <= NOP_INSTR;
            skid_pc_r    <= 32'h0000_0000;
            skid_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            req_r        <= (state_nxt_s != HOLD);
            tgt_r        <= tgt_nxt_s;
            skid_instr_r <= skid_instr_nxt_s;
            skid_pc_r    <= skid_pc_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .en         (~stall_D),
        .flush      (flush_D),
        .load_instr (load_instr_s),
        .load_pc    (load_pc_s),
        .load_valid (load_valid_s),
        .instr_D    (instr_D),
        .pc_D       (pc_D),
        .valid_D    (valid_D)
    );

endmodule
